// File: rtl/nios2_system_sw_pkg.sv
// rtl/nios2_system_sw_pkg.sv - shared constants and counter sizing for the slide-switch debouncer
package nios2_system_sw_pkg;

    localparam int SW_WIDTH            = 10;
    localparam int SW_DEBOUNCE_DEFAULT = 50000;

    // Wide enough to hold DEBOUNCE_CYCLES itself; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/nios2_system_sw_debounce_bit.sv
// rtl/nios2_system_sw_debounce_bit.sv - two-flop synchronizer, stability counter and held level for one switch bit
module nios2_system_sw_debounce_bit
    import nios2_system_sw_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_out,
    output logic sync_level,
    output logic accept
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    // High on the edge where the new level has been stable long enough to be taken.
    assign accept     = (sync2 != sw_out) && (count == TERMINAL);
    assign sync_level = sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= RESET_VAL;
            sync2  <= RESET_VAL;
            sw_out <= RESET_VAL;
            count  <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 == sw_out) begin
                count <= '0;
            end else if (count == TERMINAL) begin
                sw_out <= sync2;
                count  <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/nios2_system_sw_debounce.sv
// rtl/nios2_system_sw_debounce.sv - per-bit switch debouncer with optional edge pulses (macro SW_DEBOUNCE_EDGE_EN)
module nios2_system_sw_debounce
    import nios2_system_sw_pkg::*;
#(
    parameter int               WIDTH           = SW_WIDTH,
    parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] level;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios2_system_sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk        (clk),
            .reset      (reset),
            .sw_raw     (sw_raw[i]),
            .sw_out     (sw_out[i]),
            .sync_level (level[i]),
            .accept     (accept[i])
        );
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             changed_q;

    // Registered alongside sw_out so each pulse lines up with the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= accept & level;
            fall_q    <= accept & ~level;
            changed_q <= |accept;
        end
    end

    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;
`else
    logic edge_unused;
    assign edge_unused = ^{accept, level};
    assign sw_rise     = '0;
    assign sw_fall     = '0;
    assign sw_changed  = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_system_sw_debounce.sv
// tb/tb_nios2_system_sw_debounce.sv - directed and randomized self-checking bench for nios2_system_sw_debounce
module tb_nios2_system_sw_debounce;

    localparam int W  = 10;
    localparam int DC = 4;
`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_out;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int checks   = 0;
    int failures = 0;

    // Reference model: sampled levels pass a 2-edge delay; a bit flips once the last DC
    // compared samples since reset all disagree with the held level.
    logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic         m_chg;
    logic [W-1:0] win[$];

    nios2_system_sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VAL       ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_out     (sw_out),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] acc;
        bit           all;
        acc = '0;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_out = '0;
            m_rise = '0; m_fall = '0;
            win.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > DC) void'(win.pop_front());
            if (win.size() == DC) begin
                for (int b = 0; b < W; b++) begin
                    all = 1'b1;
                    foreach (win[k]) if (win[k][b] == m_out[b]) all = 1'b0;
                    acc[b] = all;
                end
            end
            m_rise = acc & m_s2;
            m_fall = acc & ~m_s2;
            m_out  = m_out ^ acc;
            m_s2   = m_s1;
            m_s1   = sw_raw;
        end
        m_chg = |(m_rise | m_fall);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("sw_out", sw_out, m_out);
        chk("sw_rise", sw_rise, EDGE_EN ? m_rise : '0);
        chk("sw_fall", sw_fall, EDGE_EN ? m_fall : '0);
        chk("sw_changed", W'(sw_changed), W'(EDGE_EN ? m_chg : 1'b0));
        chk("rise_fall_excl", sw_rise & sw_fall, '0);
    endtask

    function automatic logic [W-1:0] pe(input logic [W-1:0] v);
        return EDGE_EN ? v : '0;
    endfunction

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        tick();
        tick();
        chk("reset_out", sw_out, '0);
        chk("reset_rise", sw_rise, '0);
        chk("reset_chg", W'(sw_changed), '0);

        // All bits rise together
        reset  = 1'b0;
        sw_raw = 10'h3FF;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("r030_out_pre", sw_out, 10'h000);
        end
        tick();
        chk("r030_out_e6", sw_out, 10'h3FF);
        chk("r030_rise_e6", sw_rise, pe(10'h3FF));
        chk("r030_chg_e6", W'(sw_changed), pe(10'h001));
        tick();
        chk("r030_rise_e7", sw_rise, 10'h000);
        chk("r030_chg_e7", W'(sw_changed), 10'h000);

        // Glitch shorter than DC is discarded
        reset = 1'b1; sw_raw = '0;
        tick();
        reset = 1'b0; sw_raw = 10'h001;
        repeat (3) tick();
        sw_raw = 10'h000;
        repeat (8) tick();
        chk("r031_out", sw_out, 10'h000);

        // Falling acceptance on bit 0
        sw_raw = 10'h001;
        repeat (8) tick();
        chk("r032_out_hi", sw_out, 10'h001);
        sw_raw = 10'h000;
        repeat (5) tick();
        chk("r032_out_e5", sw_out, 10'h001);
        tick();
        chk("r032_out_e6", sw_out, 10'h000);
        chk("r032_fall_e6", sw_fall, pe(10'h001));
        chk("r032_rise_e6", sw_rise, 10'h000);

        // Staggered bits give separate pulses
        sw_raw = 10'h004;
        tick(); tick();
        sw_raw = 10'h084;
        repeat (3) tick();
        chk("r033_out_e5", sw_out, 10'h000);
        tick();
        chk("r033_out_e6", sw_out, 10'h004);
        chk("r033_chg_e6", W'(sw_changed), pe(10'h001));
        tick();
        chk("r033_chg_e7", W'(sw_changed), 10'h000);
        tick();
        chk("r033_out_e8", sw_out, 10'h084);
        chk("r033_rise_e8", sw_rise, pe(10'h080));

        // Reset mid-count discards progress
        reset = 1'b1; sw_raw = '0;
        tick();
        reset = 1'b0; sw_raw = 10'h010;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("r034_out_rst", sw_out, 10'h000);
        chk("r034_chg_rst", W'(sw_changed), 10'h000);
        reset = 1'b0;
        repeat (5) tick();
        chk("r034_out_e5", sw_out, 10'h000);
        tick();
        chk("r034_out_e6", sw_out, 10'h010);
        chk("r034_rise_e6", sw_rise, pe(10'h010));

        // Randomized slow-toggling switches with occasional resets
        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] flip;
            flip = '0;
            for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0) flip = '0;
            sw_raw = sw_raw ^ flip;
            reset  = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios2_system_sw_debounce.md
NIOS2_SYSTEM_SW_DEBOUNCE -- requirements
Module: nios2_system_sw_debounce

Interface
REQ-001 Parameter WIDTH, default 10, number of slide-switch bits; drives the 10-bit switch PIO input port downstream.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required before accepting a new level (1 ms at 50 MHz); legal range 1..2^20.
REQ-003 Parameter RESET_VAL, default all-zero, WIDTH-bit value loaded into synchronizer and debounced output at reset.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sw_raw  input  WIDTH  asynchronous switch pins from the board.
REQ-007 sw_out  output  WIDTH  debounced level; connects to the PIO in_port.
REQ-008 sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1 transition.
REQ-009 sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0 transition.
REQ-010 sw_changed  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits.

Function
REQ-011 Each sw_raw bit SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 is used downstream.
REQ-012 Each bit SHALL own an independent counter of width clog2(DEBOUNCE_CYCLES+1); bits never share state.
REQ-013 At each edge where sync2[i] == sw_out[i], counter[i] SHALL clear to 0.
REQ-014 At each edge where sync2[i] != sw_out[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-015 At the DEBOUNCE_CYCLES-th consecutive differing edge, sw_out[i] SHALL take sync2[i] and counter[i] SHALL clear in the same edge.
REQ-016 Total latency: a clean level change on sw_raw[i] set up before edge E1 SHALL appear on sw_out[i] after edge E(2+DEBOUNCE_CYCLES).
REQ-017 Any return of sync2[i] to sw_out[i] before acceptance (glitch) SHALL discard the count; sw_out[i] unchanged, no pulse.
REQ-018 Counters SHALL never wrap; terminal value is DEBOUNCE_CYCLES-1 and acceptance occurs there.
REQ-019 DEBOUNCE_CYCLES = 1 SHALL accept on the first differing edge (latency 3 edges).
REQ-020 sw_rise[i]/sw_fall[i] SHALL be registered, asserted for exactly the cycle after the edge where sw_out[i] updates, aligned with the new sw_out value.
REQ-021 Simultaneous acceptance on several bits SHALL raise all corresponding pulse bits in the same cycle and a single sw_changed pulse.
REQ-022 sw_rise and sw_fall SHALL never both be high for the same bit.

Reset
REQ-023 While reset is high at an edge: sync1, sync2, sw_out <= RESET_VAL; all counters <= 0; sw_rise, sw_fall, sw_changed <= 0.
REQ-024 Reset asserted mid-count SHALL discard the count; no pulse SHALL be generated by reset itself, even if RESET_VAL differs from prior sw_out.
REQ-025 After reset deassertion, a sw_raw value differing from RESET_VAL SHALL be accepted with normal latency (REQ-016) and SHALL pulse.

Configuration
REQ-026 Macro SW_DEBOUNCE_EDGE_EN: when defined, sw_rise, sw_fall, sw_changed behave per REQ-020..022.
REQ-027 When SW_DEBOUNCE_EDGE_EN is undefined, edge logic SHALL be compiled out and sw_rise, sw_fall, sw_changed tied to constant 0; sw_out behaviour identical.

Structure
REQ-028 Shared package nios2_system_sw_pkg SHALL hold SW_WIDTH (10), SW_DEBOUNCE_DEFAULT (50000), and the counter-width function.
REQ-029 One sub-module, nios2_system_sw_debounce_bit (sync + counter + stable flop for one bit), SHALL be instantiated WIDTH times by a generate loop; edge/OR logic lives in the top.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=10, RESET_VAL=0)
REQ-030 Reset, sw_raw=10'h3FF held -> sw_out=0 through edge E5, sw_out=10'h3FF after E6, sw_rise=10'h3FF and sw_changed=1 for exactly one cycle.
REQ-031 sw_out=0, sw_raw[0] high for 3 cycles then low -> sw_out stays 10'h000, no pulses.
REQ-032 sw_out=10'h001, sw_raw[0] low for 4+ cycles -> sw_out=10'h000 after 6th edge, sw_fall=10'h001 one cycle, sw_rise=0.
REQ-033 Bit 2 rises at E1, bit 7 rises at E3 -> bit 2 accepted after E6, bit 7 after E8; two separate sw_changed pulses.
REQ-034 sw_raw=10'h010, reset pulsed at edge where counter[4]=2 -> sw_out=0, no pulse; bit 4 accepted 6 edges after reset release.
REQ-035 Build without SW_DEBOUNCE_EDGE_EN, rerun REQ-030 -> identical sw_out timing, sw_rise/sw_fall/sw_changed constantly 0.
